// File: rtl/gradient_magnitude_if.sv
// Gradient-magnitude stream interface.
//   in_valid  : gx/gy carry a valid sample this cycle
//   gx, gy    : signed two's complement gradients (DATA_W bits)
//   out_valid : gmag carries a valid result this cycle
//   gmag      : unsigned saturated gradient magnitude (DATA_W bits)
// Modports:
//   master : the side that produces samples and consumes results
//   slave  : the gradient_magnitude stage itself
interface gradient_magnitude_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] gx;
    logic [DATA_W-1:0] gy;
    logic              out_valid;
    logic [DATA_W-1:0] gmag;

    modport master (
        output in_valid,
        output gx,
        output gy,
        input  out_valid,
        input  gmag
    );

    modport slave (
        input  in_valid,
        input  gx,
        input  gy,
        output out_valid,
        output gmag
    );
endinterface

// File: rtl/gradient_magnitude.sv
// Gradient-magnitude stage of the Canny pipeline (between Sobel and NMS).
// Two-stage pipeline, one result per clock, fixed latency of 2 cycles.
//   stage 1 : ax = |gx|, ay = |gy| (unsigned, |-2^(DATA_W-1)| does not wrap)
//   stage 2 : gmag = saturate(ax + ay) to DATA_W bits
// Optional build macro GMAG_ALPHA_MAX_EN: stage 2 uses
//   max(ax, ay) + (min(ax, ay) >> 1) instead of ax + ay, same saturation.
// Ports:
//   clk   : system clock, rising edge
//   n_rst : synchronous active-low reset
//   bus   : gradient_magnitude_if.slave (in_valid, gx, gy, out_valid, gmag)
module gradient_magnitude #(
    parameter int DATA_W = 8
) (
    input logic                 clk,
    input logic                 n_rst,
    gradient_magnitude_if.slave bus
);

    localparam logic [DATA_W-1:0] one = DATA_W'(1);

    logic              s1_valid;
    logic [DATA_W-1:0] ax;
    logic [DATA_W-1:0] ay;
    logic              s2_valid;
    logic [DATA_W-1:0] s2_gmag;
    logic [DATA_W:0]   sum;

    // Two's complement negate of the most negative value yields the
    // same bit pattern, which read as unsigned is exactly 2^(DATA_W-1).
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
        abs_val = v[DATA_W-1] ? ((~v) + one) : v;
    endfunction

`ifdef GMAG_ALPHA_MAX_EN
    logic [DATA_W-1:0] mx;
    logic [DATA_W-1:0] mn;

    always_comb begin
        mx  = ax;
        mn  = ay;
        if (ay > ax) begin
            mx = ay;
            mn = ax;
        end
        sum = {1'b0, mx} + {2'b00, mn[DATA_W-1:1]};
    end
`else
    always_comb begin
        sum = {1'b0, ax} + {1'b0, ay};
    end
`endif

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            s1_valid <= 1'b0;
            ax       <= '0;
            ay       <= '0;
            s2_valid <= 1'b0;
            s2_gmag  <= '0;
        end else begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                ax <= abs_val(bus.gx);
                ay <= abs_val(bus.gy);
            end
            s2_valid <= s1_valid;
            // gmag holds its last result across bubbles
            if (s1_valid) begin
                s2_gmag <= sum[DATA_W] ? '1 : sum[DATA_W-1:0];
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.gmag      = s2_gmag;

endmodule

// File: tb/tb_gradient_magnitude.sv
// Directed bench for gradient_magnitude. Inputs are driven on the falling
// edge; outputs are checked on the falling edge before new inputs are driven,
// against hand-computed expected values delayed by the 2-cycle latency.
`ifdef GMAG_ALPHA_MAX_EN
`define GM(l1, am) (am)
`else
`define GM(l1, am) (l1)
`endif

module tb_gradient_magnitude;

    logic clk;
    logic n_rst;

    gradient_magnitude_if #(.DATA_W(8)) bus ();

    gradient_magnitude #(.DATA_W(8)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // expected-result delay line (hand values, shifted by latency)
    logic       pv [0:1];
    logic [7:0] pg [0:1];
    logic [7:0] e_hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One cycle: check current outputs, then drive the next inputs.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [7:0] x, input logic [7:0] y, input logic [7:0] e);
        @(negedge clk);
        if (pv[1]) e_hold = pg[1];
        chk({tag, ".out_valid"}, {31'b0, bus.out_valid}, {31'b0, pv[1]});
        chk({tag, ".gmag"}, {24'b0, bus.gmag}, {24'b0, e_hold});
        pv[1] = pv[0];
        pg[1] = pg[0];
        pv[0] = v & r;
        pg[0] = e;
        if (!r) begin
            pv[1]  = 1'b0;
            pv[0]  = 1'b0;
            e_hold = 8'd0;
        end
        n_rst        = r;
        bus.in_valid = v;
        bus.gx       = x;
        bus.gy       = y;
    endtask

    initial begin
        pv[0] = 1'b0; pv[1] = 1'b0;
        pg[0] = 8'd0; pg[1] = 8'd0;
        e_hold = 8'd0;
        n_rst        = 1'b0;
        bus.in_valid = 1'b1;
        bus.gx       = 8'h55;
        bus.gy       = 8'h33;

        // reset held with valid nonzero inputs
        for (int i = 0; i < 3; i++) step("rst", 1'b0, 1'b1, 8'h55, 8'h33, 8'd0);

        // back-to-back stream
        step("s0", 1'b1, 1'b1, 8'd0,   8'd0,   `GM(8'd0,   8'd0));
        step("s1", 1'b1, 1'b1, 8'd192, 8'd192, `GM(8'd128, 8'd96));
        step("s2", 1'b1, 1'b1, 8'd1,   8'd1,   `GM(8'd2,   8'd1));
        step("s3", 1'b1, 1'b1, 8'd191, 8'd191, `GM(8'd130, 8'd97));
        step("s4", 1'b1, 1'b1, 8'd95,  8'd95,  `GM(8'd190, 8'd142));
        step("s_idle0", 1'b1, 1'b0, 8'd7, 8'd9, 8'd0);
        step("s_idle1", 1'b1, 1'b0, 8'd7, 8'd9, 8'd0);

        // saturation and most-negative input
        step("sat0", 1'b1, 1'b1, 8'h80, 8'h80, `GM(8'd255, 8'd192));
        step("sat1", 1'b1, 1'b1, 8'd127, 8'h80, `GM(8'd255, 8'd191));
        step("sat2", 1'b1, 1'b1, 8'd127, 8'd0, `GM(8'd127, 8'd127));
        step("sat3", 1'b1, 1'b1, 8'h80, 8'd0,  `GM(8'd128, 8'd128));
        step("sat_idle0", 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        step("sat_idle1", 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);

        // bubbles 1,0,1,1,0 (inputs change during bubbles, must be ignored)
        step("bub0", 1'b1, 1'b1, 8'd10,  8'd20,  `GM(8'd30, 8'd25));
        step("bub1", 1'b1, 1'b0, 8'd100, 8'd100, 8'd0);
        step("bub2", 1'b1, 1'b1, 8'd3,   8'd253, `GM(8'd6, 8'd4));
        step("bub3", 1'b1, 1'b1, 8'd255, 8'd0,   `GM(8'd1, 8'd1));
        step("bub4", 1'b1, 1'b0, 8'd60,  8'd60,  8'd0);
        step("bub5", 1'b1, 1'b0, 8'd60,  8'd60,  8'd0);
        step("bub6", 1'b1, 1'b0, 8'd60,  8'd60,  8'd0);

        // reset mid-stream: second sample is in flight and must not emerge
        step("mr0", 1'b1, 1'b1, 8'd50, 8'd50, `GM(8'd100, 8'd75));
        step("mr1", 1'b1, 1'b1, 8'd20, 8'd30, `GM(8'd50, 8'd40));
        step("mr_rst", 1'b0, 1'b1, 8'd44, 8'd44, 8'd0);
        step("mr_idle0", 1'b1, 1'b0, 8'd44, 8'd44, 8'd0);
        step("mr_idle1", 1'b1, 1'b0, 8'd44, 8'd44, 8'd0);
        step("mr_first", 1'b1, 1'b1, 8'd5, 8'd6, `GM(8'd11, 8'd8));
        step("mr_idle2", 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);

        // norm comparison set (L1 vs alpha-max-beta-min)
        step("n0", 1'b1, 1'b1, 8'd95,  8'd95,  `GM(8'd190, 8'd142));
        step("n1", 1'b1, 1'b1, 8'd192, 8'd192, `GM(8'd128, 8'd96));
        step("n2", 1'b1, 1'b1, 8'h80,  8'h80,  `GM(8'd255, 8'd192));
        step("n3", 1'b1, 1'b1, 8'd127, 8'd127, `GM(8'd254, 8'd190));
        step("n4", 1'b1, 1'b1, 8'd100, 8'd20,  `GM(8'd120, 8'd110));
        step("n5", 1'b1, 1'b1, 8'd20,  8'd100, `GM(8'd120, 8'd110));
        step("n_idle0", 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        step("n_idle1", 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        step("n_idle2", 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`undef GM

// File: doc/gradient_magnitude.md
Name: gradient_magnitude

Overview:
Gradient-magnitude stage of the pipelined Canny edge detector. It sits between the Sobel convolution stage and non-maximum suppression. Each valid cycle it accepts one signed horizontal/vertical gradient pair (gx, gy) and produces an unsigned, saturated edge-strength value gmag. The block is fully pipelined: one result per clock, fixed latency.

Parameters:
DATA_W, 8, width of gx, gy and gmag in bits. gx and gy are two's complement; gmag is unsigned.

Ports:
clk  input  1  system clock; all state updates on rising edge
n_rst  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  gx/gy hold a valid sample this cycle
gx  input  DATA_W  signed horizontal gradient, two's complement
gy  input  DATA_W  signed vertical gradient, two's complement
out_valid  output  1  gmag holds the result for the sample accepted 2 cycles earlier
gmag  output  DATA_W  unsigned saturated gradient magnitude

Behaviour:
- Reset: when n_rst=0 at a rising edge, clear all pipeline registers, out_valid=0 and gmag=0. There is no asynchronous path.
- Reset mid-operation discards every in-flight sample. The first result after reset is the first sample presented with in_valid=1 while n_rst=1.
- Stage 1 (registered), computed when in_valid=1:
  - ax=|gx| and ay=|gy|, each DATA_W bits unsigned.
  - |-2^(DATA_W-1)| = 2^(DATA_W-1). For example |-128| = 128; the value must not wrap.
- Stage 2 (registered):
  - sum = ax + ay, computed at DATA_W+1 bits.
  - gmag = sum if sum <= 2^DATA_W - 1, otherwise all ones (255).
- Latency is exactly 2 cycles from in_valid to out_valid. Throughput is 1 sample per cycle. No backpressure.
- The valid bit travels with the data through both stages.
- When in_valid=0, a bubble propagates: out_valid=0 two cycles later.
- While out_valid=0, gmag holds its previous value. Downstream logic must ignore gmag when out_valid=0.
- Input encodings with DATA_W=8:
  - 192 is -64 and 191 is -65.
  - 0x80 (-128) is the most negative input.
- Boundary results with DATA_W=8:
  - gx=gy=0 gives 0.
  - gx=gy=-128 gives raw 256, saturated to 255.
  - gx=127, gy=-128 gives 255.
  - gx=127, gy=0 gives 127.
- No X propagation: every register has a defined reset value.

Optional Feature:
Macro GMAG_ALPHA_MAX_EN.
- Defined: stage 2 uses the alpha-max-beta-min approximation of the Euclidean norm.
  - mx = max(ax, ay), mn = min(ax, ay).
  - sum = mx + (mn >> 1), computed at DATA_W+1 bits, with the same saturation to all ones.
  - Latency, valid timing and reset behaviour are unchanged.
- Not defined: the L1 norm above (ax + ay) is used. This is the default build.

Test Plan:
- Reset: hold n_rst=0 for 3 cycles with in_valid=1 and nonzero inputs -> out_valid=0 and gmag=0 throughout. Release reset -> first out_valid exactly 2 cycles after the first accepted sample.
- Directed L1 stream, back-to-back with in_valid=1, expected gmag with 2-cycle latency and out_valid high for 5 consecutive cycles:
  - (0,0) -> 0
  - (192,192) -> 128
  - (1,1) -> 2
  - (191,191) -> 130
  - (95,95) -> 190
- Saturation / most-negative input:
  - (0x80,0x80) -> 255
  - (127,0x80) -> 255
  - (127,0) -> 127
  - (0x80,0) -> 128
- Bubbles: in_valid pattern 1,0,1,1,0 -> out_valid pattern 0,0,1,0,1,1,0. Data stays aligned with its valid.
- Reset mid-stream: assert n_rst=0 for one cycle while 2 samples are in flight -> neither emerges, and out_valid=0 on the next 2 cycles unless new samples are accepted.
- With GMAG_ALPHA_MAX_EN defined:
  - (95,95) -> 142
  - (192,192) -> 96
  - (0x80,0x80) -> 192
  - (127,127) -> 190
  - (100,20) -> 110
